// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised raster timing generator driven by a single pixel clock.
// Produces the current pixel position, an active-video flag aligned with that
// position, line/frame start markers, and hsync/vsync/blank delayed by PIPE
// enabled cycles so they can line up with a downstream pixel pipeline.
//
// Ports:
//   pixel_clk   in   pixel clock (only clock)
//   rst         in   synchronous active-high reset, overrides en
//   en          in   advance enable; all state holds while low
//   hcount      out  current column, 0..H_TOTAL-1
//   vcount      out  current line,   0..V_TOTAL-1
//   active      out  position is inside the visible area (aligned with counts)
//   line_start  out  hcount == 0, qualified by en
//   frame_start out  hcount == 0 and vcount == 0, qualified by en
//   hsync       out  horizontal sync, PIPE en-cycles behind the counts
//   vsync       out  vertical sync,   PIPE en-cycles behind the counts
//   blank       out  inverse of active, PIPE en-cycles behind the counts
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 56,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 41,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0,
  parameter int PIPE     = 0,
  parameter int CW       = 11
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          blank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  // Range bounds carry one extra bit: a sync window may end exactly at 2^CW.
  localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // {hsync, vsync, blank} idle value used for reset and pipeline flush.
  localparam logic [2:0] STAGE_IDLE = {~H_POL, ~V_POL, 1'b1};

  logic [CW-1:0] r_hcount;
  logic [CW-1:0] r_vcount;
  logic          r_active;
  logic          r_hs0;
  logic          r_vs0;
  logic          r_blank0;

  logic          w_h_last;
  logic          w_v_last;
  logic [CW-1:0] w_h_next;
  logic [CW-1:0] w_v_next;
  logic [CW:0]   w_h_ext;
  logic [CW:0]   w_v_ext;
  logic          w_act_next;
  logic          w_hs_next;
  logic          w_vs_next;

  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);
  assign w_h_next = w_h_last ? '0 : r_hcount + CW'(1);
  assign w_v_next = w_h_last ? (w_v_last ? '0 : r_vcount + CW'(1)) : r_vcount;

  // Decode from the next position so the registered flags describe the
  // position that becomes visible on the same edge.
  assign w_h_ext    = {1'b0, w_h_next};
  assign w_v_ext    = {1'b0, w_v_next};
  assign w_act_next = (w_h_ext < H_ACT_END) && (w_v_ext < V_ACT_END);
  assign w_hs_next  = ((w_h_ext >= H_SYNC_BEG) && (w_h_ext < H_SYNC_END)) ? H_POL : ~H_POL;
  assign w_vs_next  = ((w_v_ext >= V_SYNC_BEG) && (w_v_ext < V_SYNC_END)) ? V_POL : ~V_POL;

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_active <= 1'b1;
      // Stage 0 starts idle (blank high) even though (0,0) is visible, so no
      // partial sync or video escapes right after reset.
      {r_hs0, r_vs0, r_blank0} <= STAGE_IDLE;
    end else if (en) begin
      r_hcount <= w_h_next;
      r_vcount <= w_v_next;
      r_active <= w_act_next;
      r_hs0    <= w_hs_next;
      r_vs0    <= w_vs_next;
      r_blank0 <= ~w_act_next;
    end
  end

  // Delay chain: w_chain[0] is stage 0, w_chain[k] is k en-cycles behind it.
  logic [PIPE:0][2:0] w_chain;
  assign w_chain[0] = {r_hs0, r_vs0, r_blank0};

  for (genvar gi = 0; gi < PIPE; gi++) begin : g_stage
    logic [2:0] r_q;
    always_ff @(posedge pixel_clk) begin
      if (rst) begin
        r_q <= STAGE_IDLE;
      end else if (en) begin
        r_q <= w_chain[gi];
      end
    end
    assign w_chain[gi+1] = r_q;
  end

  assign {hsync, vsync, blank} = w_chain[PIPE];

  assign hcount      = r_hcount;
  assign vcount      = r_vcount;
  assign active      = r_active;
  assign line_start  = (r_hcount == '0) && en;
  assign frame_start = (r_hcount == '0) && (r_vcount == '0) && en;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, default with
// PIPE=3, and a tiny 8x5 geometry with positive sync polarity) share rst/en.
// A position counter p (en edges since reset) feeds an arithmetic model of
// what every output must be; directed phases add hand-computed literals.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hfp; int hsw; int hbp;
    int va; int vfp; int vsw; int vbp;
    int pipe;
    bit hpol; bit vpol;
  } cfg_t;

  localparam cfg_t C0 = '{ha:640, hfp:8, hsw:96, hbp:56, va:480, vfp:2, vsw:2, vbp:41,
                          pipe:0, hpol:1'b0, vpol:1'b0};
  localparam cfg_t C3 = '{ha:640, hfp:8, hsw:96, hbp:56, va:480, vfp:2, vsw:2, vbp:41,
                          pipe:3, hpol:1'b0, vpol:1'b0};
  localparam cfg_t CS = '{ha:4, hfp:1, hsw:2, hbp:1, va:2, vfp:1, vsw:1, vbp:1,
                          pipe:0, hpol:1'b1, vpol:1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic en  = 1'b1;

  logic [10:0] h0, v0, h3, v3;
  logic [3:0]  hs_cnt, vs_cnt;
  logic act0, ls0, fs0, hs0, vs0, bl0;
  logic act3, ls3, fs3, hsy3, vsy3, bl3;
  logic act_s, ls_s, fs_s, hs_s, vs_s, bl_s;

  vga_timing_gen u_dut0 (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hcount(h0), .vcount(v0), .active(act0), .line_start(ls0), .frame_start(fs0),
    .hsync(hs0), .vsync(vs0), .blank(bl0)
  );

  vga_timing_gen #(.PIPE(3)) u_dut3 (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hcount(h3), .vcount(v3), .active(act3), .line_start(ls3), .frame_start(fs3),
    .hsync(hsy3), .vsync(vsy3), .blank(bl3)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIPE(0), .CW(4)
  ) u_dsm (
    .pixel_clk(clk), .rst(rst), .en(en),
    .hcount(hs_cnt), .vcount(vs_cnt), .active(act_s), .line_start(ls_s), .frame_start(fs_s),
    .hsync(hs_s), .vsync(vs_s), .blank(bl_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int p_cnt = 0;
  bit model_valid = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d, expected %0d (p=%0d, t=%0t)", name, act, exp, p_cnt, $time);
    end
  endtask

  // Expected outputs at linear position p: counts are p folded by the totals;
  // delayed signals are the stage-0 value of position p-PIPE, idle before that.
  task automatic model_check(input cfg_t c, input string tag, input int p, input bit e,
                             input int h, input int v, input logic act, input logic ls,
                             input logic fs, input logic hs, input logic vs, input logic bl);
    int ht, vt, eh, ev, q, hq, vq;
    int e_hs, e_vs, e_bl;
    ht = c.ha + c.hfp + c.hsw + c.hbp;
    vt = c.va + c.vfp + c.vsw + c.vbp;
    eh = p % ht;
    ev = (p / ht) % vt;
    if (p < c.pipe) begin
      e_hs = int'(!c.hpol);
      e_vs = int'(!c.vpol);
      e_bl = 1;
    end else begin
      q  = p - c.pipe;
      hq = q % ht;
      vq = (q / ht) % vt;
      e_hs = (hq >= c.ha + c.hfp && hq < c.ha + c.hfp + c.hsw) ? int'(c.hpol) : int'(!c.hpol);
      e_vs = (vq >= c.va + c.vfp && vq < c.va + c.vfp + c.vsw) ? int'(c.vpol) : int'(!c.vpol);
      e_bl = (q == 0) ? 1 : int'(!(hq < c.ha && vq < c.va));
    end
    chk({tag, ".hcount"}, h, eh);
    chk({tag, ".vcount"}, v, ev);
    chk({tag, ".active"}, int'(act), int'(eh < c.ha && ev < c.va));
    chk({tag, ".line_start"}, int'(ls), int'(eh == 0 && e));
    chk({tag, ".frame_start"}, int'(fs), int'(eh == 0 && ev == 0 && e));
    chk({tag, ".hsync"}, int'(hs), e_hs);
    chk({tag, ".vsync"}, int'(vs), e_vs);
    chk({tag, ".blank"}, int'(bl), e_bl);
  endtask

  // Model position tracks the same edges the DUTs see.
  always @(posedge clk) begin
    if (rst) begin
      p_cnt       <= 0;
      model_valid <= 1'b1;
    end else if (en) begin
      p_cnt <= p_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      model_check(C0, "d0", p_cnt, en, int'(h0), int'(v0), act0, ls0, fs0, hs0, vs0, bl0);
      model_check(C3, "d3", p_cnt, en, int'(h3), int'(v3), act3, ls3, fs3, hsy3, vsy3, bl3);
      model_check(CS, "ds", p_cnt, en, int'(hs_cnt), int'(vs_cnt), act_s, ls_s, fs_s, hs_s, vs_s, bl_s);
    end
  end

  int a_hs_lo0, a_hs_lo3, a_ls0, a_fs_s, a_hs_hi_s, a_vs_hi_s, a_act_s, a_bl_s;
  int fall_h0, fall_h3, rise_b0, rise_b3;
  logic prev_hs0, prev_hs3, prev_bl0, prev_bl3;
  int b_hs_lo, b_ls, b_ls_bad;

  initial begin
    a_hs_lo0 = 0; a_hs_lo3 = 0; a_ls0 = 0; a_fs_s = 0;
    a_hs_hi_s = 0; a_vs_hi_s = 0; a_act_s = 0; a_bl_s = 0;
    fall_h0 = -1; fall_h3 = -1; rise_b0 = -1; rise_b3 = -1;
    prev_hs0 = 1'b1; prev_hs3 = 1'b1; prev_bl0 = 1'b1; prev_bl3 = 1'b1;
    b_hs_lo = 0; b_ls = 0; b_ls_bad = 0;

    // Phase 1: power-on reset, then run two lines with en held high.
    rst = 1'b1; en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst0.hcount", int'(h0), 0);
    chk("rst0.vcount", int'(v0), 0);
    chk("rst0.hsync", int'(hs0), 1);
    chk("rst0.vsync", int'(vs0), 1);
    chk("rst0.blank", int'(bl0), 1);
    chk("rst0.active", int'(act0), 1);
    chk("rst0.frame_start", int'(fs0), 1);
    chk("rst0.d3_blank", int'(bl3), 1);
    chk("rst0.ds_hsync", int'(hs_s), 0);
    chk("rst0.ds_vsync", int'(vs_s), 0);

    for (int c = 0; c < 1600; c++) begin
      if (!hs0)  a_hs_lo0++;
      if (!hsy3) a_hs_lo3++;
      if (ls0)   a_ls0++;
      if (fs_s)  a_fs_s++;
      if (hs_s)  a_hs_hi_s++;
      if (vs_s)  a_vs_hi_s++;
      if (act_s) a_act_s++;
      if (bl_s)  a_bl_s++;
      if (c > 0) begin
        if (prev_hs0 && !hs0 && fall_h0 < 0)  fall_h0 = int'(h0);
        if (prev_hs3 && !hsy3 && fall_h3 < 0) fall_h3 = int'(h3);
        if (!prev_bl0 && bl0 && rise_b0 < 0)  rise_b0 = int'(h0);
        if (!prev_bl3 && bl3 && rise_b3 < 0)  rise_b3 = int'(h3);
      end
      prev_hs0 = hs0; prev_hs3 = hsy3; prev_bl0 = bl0; prev_bl3 = bl3;
      @(negedge clk);
    end
    chk("line.d0_hsync_low_cycles", a_hs_lo0, 192);
    chk("line.d3_hsync_low_cycles", a_hs_lo3, 192);
    chk("line.d0_line_start_pulses", a_ls0, 2);
    chk("line.d0_hsync_fall_hcount", fall_h0, 648);
    chk("line.d3_hsync_fall_hcount", fall_h3, 651);
    chk("line.d0_blank_rise_hcount", rise_b0, 640);
    chk("line.d3_blank_rise_hcount", rise_b3, 643);
    chk("line.d0_hcount_after_2_lines", int'(h0), 0);
    chk("line.d0_vcount_after_2_lines", int'(v0), 2);
    chk("small.frame_starts", a_fs_s, 40);
    chk("small.hsync_high_cycles", a_hs_hi_s, 400);
    chk("small.vsync_high_cycles", a_vs_hi_s, 320);
    chk("small.active_cycles", a_act_s, 320);
    chk("small.blank_cycles", a_bl_s, 1281);

    // Phase 2: reset mid-line with en low (reset must still win).
    repeat (123) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1; en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; en = 1'b1;
    @(negedge clk);
    chk("rst1.hcount", int'(h0), 0);
    chk("rst1.vcount", int'(v0), 0);
    chk("rst1.hsync", int'(hs0), 1);
    chk("rst1.vsync", int'(vs0), 1);
    chk("rst1.blank", int'(bl0), 1);
    chk("rst1.frame_start", int'(fs0), 1);

    // Phase 3: en toggling every clock, starting high.
    for (int c = 0; c < 1600; c++) begin
      if (!hs0) b_hs_lo++;
      if (ls0) b_ls++;
      if (ls0 && !en) b_ls_bad++;
      @(posedge clk);
      #1 en = ~en;
      @(negedge clk);
    end
    chk("en.hsync_low_clocks", b_hs_lo, 192);
    chk("en.line_start_pulses", b_ls, 1);
    chk("en.line_start_while_en_low", b_ls_bad, 0);
    chk("en.hcount_after_800_en", int'(h0), 0);
    chk("en.vcount_after_800_en", int'(v0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/raster timing generator. It is the successor to the fixed 640x480 controller. It produces pixel coordinates, sync, blanking and frame/line markers from one pixel clock. It sits between the pixel clock source and the frame-buffer read and colour-output path. Versus the old controller it adds:
- a synchronous reset
- a clock enable
- configurable geometry and sync polarity
- correct wrap (exact H/V totals)
- all outputs registered and mutually aligned
- a configurable sync/blank delay that matches downstream pixel latency

## Interface
- H_ACTIVE, 640, visible columns
- H_FP, 8, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 56, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
- V_ACTIVE, 480, visible lines
- V_FP, 2, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 41, vertical back porch (lines); V_TOTAL = 525
- H_POL, 0, hsync asserted level (0 = active-low)
- V_POL, 0, vsync asserted level
- PIPE, 0, delay of hsync/vsync/blank behind hcount/vcount, 0..7 en-cycles
- CW, 11, counter width; requires H_TOTAL <= 2^CW and V_TOTAL <= 2^CW

Ports:
- pixel_clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance enable; when low, all state holds
- hcount  out  CW  current column, 0..H_TOTAL-1
- vcount  out  CW  current line, 0..V_TOTAL-1
- active  out  1  hcount < H_ACTIVE and vcount < V_ACTIVE; aligned with the counts
- line_start  out  1  hcount == 0 and en
- frame_start  out  1  hcount == 0, vcount == 0 and en
- hsync  out  1  horizontal sync, PIPE en-cycles behind the counts
- vsync  out  1  vertical sync, PIPE en-cycles behind the counts
- blank  out  1  ~active, PIPE en-cycles behind the counts

## Operation
- hcount increments on each en cycle. At H_TOTAL-1 it wraps to 0.
- vcount increments only on an en cycle where hcount == H_TOTAL-1. At V_TOTAL-1 it wraps to 0, simultaneously with the hcount wrap.
- Undelayed sync decode is a function of the current counts:
  - hs0 = H_POL when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vs0 = V_POL when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, else ~V_POL.
  - vs0 is a per-line decode, so it transitions at hcount == 0.
- active, hs0 and vs0 are all registered. They are decoded from the next-count values, so each describes the hcount/vcount visible in the same cycle.
- Delay line for PIPE > 0:
  - {hs0, vs0, ~active} feed a PIPE-deep shift register that advances only when en = 1.
  - PIPE = 0: hsync, vsync and blank equal the stage-0 values.
- line_start and frame_start are combinational ANDs of registered state with en, so they fire once per en-qualified position.
- Comparisons are unsigned at width CW. No arithmetic overflow is possible given the CW legality rule.

## Timing
- Reset values, one cycle after rst is sampled high:
  - hcount = 0, vcount = 0, active = 1
  - hsync = ~H_POL, vsync = ~V_POL, blank = 1
  - all delay stages = {~H_POL, ~V_POL, 1}
- rst overrides en. Reset mid-line or mid-frame restarts at (0,0) in the next cycle with no partial-sync output.
- After rst deasserts with en = 1, the first cycle shows (0,0) with frame_start = 1. The counts advance on the following edge.
- The first PIPE en-cycles after reset present blank = 1 and sync deasserted (pipeline flush), even though active = 1.
- en low: counts, stage-0 values and delay stages hold; line_start and frame_start are 0. Sync widths are measured in en-cycles.
- Latency:
  - counts to active: 0 cycles
  - counts to hsync/vsync/blank: PIPE en-cycles
- Line period: H_TOTAL en-cycles. Frame period: H_TOTAL*V_TOTAL en-cycles.

## Test plan
- Reset: assert rst for 3 cycles mid-frame at (500,300) -> next cycle shows hcount = 0, vcount = 0, hsync = 1, vsync = 1, blank = 1. The first en cycle after release shows frame_start = 1.
- Line wrap (defaults, en = 1): hcount 799 -> 0 and vcount n -> n+1 on the same edge. line_start is high exactly once per 800 cycles. hsync is low for hcount 648..743 (96 cycles). blank rises at hcount 640.
- Frame wrap: at (799,524) the next cycle is (0,0) with frame_start = 1. vsync is low for vcount 482..483 (1600 cycles). Frame period is 420000 cycles.
- PIPE = 3: hsync falls 3 cycles after hcount == 648. blank rises 3 cycles after hcount == 640. active stays aligned with the counts.
- en gating: toggle en 1/0 each cycle -> counts advance every other cycle, hsync is low for 192 clocks, and line_start pulses only when en = 1.
- Small geometry with polarity: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, H_POL=1, V_POL=1 -> hsync is high at hcount 5..6, vsync is high for all of line 3, and the frame is 40 cycles.
